// File: rtl/rc4_pkg.sv
// Shared types for the RC4 keystream generator: FSM states, S-box depth, byte type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rc4_pkg;

    localparam int RC4_SBOX_DEPTH = 256;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        KEYLOAD,
        INIT,
        KSA_J,
        KSA_SW,
        PRGA_J,
        PRGA_SW,
        HOLD
    } rc4_state_e;

endpackage

// File: rtl/rc4_sbox.sv
// RC4 permutation store: 256x8 array, three combinational read ports, identity fill and swap writes.
// Latency: reads are same-cycle; writes land on the next rising edge.
// Backpressure: none; writes happen whenever a strobe is high.
//
// Ports: i_idx/j_idx/t_idx read addresses -> s_i/s_j/s_t.
//        init_wr writes S[i_idx]=i_idx; swap_wr exchanges S[i_idx] and S[j_idx].
module rc4_sbox
    import rc4_pkg::*;
(
    input  logic  clk,
    input  byte_t i_idx,
    input  byte_t j_idx,
    input  byte_t t_idx,
    input  logic  init_wr,
    input  logic  swap_wr,
    output byte_t s_i,
    output byte_t s_j,
    output byte_t s_t
);

    // Contents are meaningless until INIT has filled them, so no reset.
    byte_t mem [RC4_SBOX_DEPTH];

    assign s_i = mem[i_idx];
    assign s_j = mem[j_idx];
    assign s_t = mem[t_idx];

    // When i_idx == j_idx both writes carry the same value, so the swap is a no-op.
    always_ff @(posedge clk) begin
        if (init_wr) begin
            mem[i_idx] <= i_idx;
        end else if (swap_wr) begin
            mem[i_idx] <= s_j;
            mem[j_idx] <= s_i;
        end
    end

endmodule

// File: rtl/rc4_keystream.sv
// RC4 keystream generator: byte-wise key load, KSA, optional drop of first N bytes, streamed output.
// Latency: key_last beat to first ks_valid = 256 + 512 + 2*(drop+1) cycles; then 1 byte / 3 cycles.
// Backpressure: ks_valid/ks_data hold in HOLD until ks_ready; key_ready only high in KEYLOAD.
//
// Ports: clk, rst (async active-low), rekey (sync abort to KEYLOAD),
//        key_valid/key_data/key_last/key_ready key input, discard (sampled on the last key beat),
//        ks_valid/ks_data/ks_ready keystream output, busy (INIT, KSA and discarding).
// Build option: define RC4_DISCARD_EN to enable the drop counter; otherwise discard is ignored.
module rc4_keystream
    import rc4_pkg::*;
#(
    parameter int MAX_KEY_BYTES = 32,
    parameter int DISCARD_W     = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rekey,
    input  logic                 key_valid,
    input  logic [7:0]           key_data,
    input  logic                 key_last,
    output logic                 key_ready,
    input  logic [DISCARD_W-1:0] discard,
    output logic                 ks_valid,
    output logic [7:0]           ks_data,
    input  logic                 ks_ready,
    output logic                 busy
);

    localparam int KIDX_W = (MAX_KEY_BYTES > 1) ? $clog2(MAX_KEY_BYTES) : 1;
    localparam logic [KIDX_W-1:0] LEN_LAST = KIDX_W'(MAX_KEY_BYTES - 1);

    rc4_state_e        state, state_nxt;
    byte_t             i_q, j_q;
    logic [KIDX_W-1:0] len_q;
    logic [KIDX_W-1:0] klen_m1_q;   // key length minus one, so it fits the index width
    logic [KIDX_W-1:0] kidx_q;      // i mod klen, tracked incrementally
    logic              emitted_q;   // at least one byte produced since the key was loaded
    byte_t             key_mem [MAX_KEY_BYTES];

    byte_t s_i, s_j, s_t, t_idx, out_byte;
    logic  key_acc, last_beat, drop, init_wr, swap_wr;

    assign key_ready = (state == KEYLOAD);
    assign key_acc   = key_valid && key_ready && !rekey;
    assign last_beat = key_last || (len_q == LEN_LAST);
    assign t_idx     = s_i + s_j;

    // S[t] after the swap, formed from pre-swap reads.
    always_comb begin
        if (t_idx == i_q)      out_byte = s_j;
        else if (t_idx == j_q) out_byte = s_i;
        else                   out_byte = s_t;
    end

`ifdef RC4_DISCARD_EN
    logic [DISCARD_W-1:0] dcnt_q;

    assign drop = (dcnt_q != '0);

    // Loaded when the key completes; it is untouched until PRGA, which makes
    // this equivalent to loading it at the end of KSA.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dcnt_q <= '0;
        end else if (key_acc && last_beat) begin
            dcnt_q <= discard;
        end else if (state == PRGA_SW && drop && !rekey) begin
            dcnt_q <= dcnt_q - 1'b1;
        end
    end
`else
    logic unused_discard;
    assign unused_discard = ^discard;
    assign drop = 1'b0;
`endif

    rc4_sbox u_sbox (
        .clk     (clk),
        .i_idx   (i_q),
        .j_idx   (j_q),
        .t_idx   (t_idx),
        .init_wr (init_wr),
        .swap_wr (swap_wr),
        .s_i     (s_i),
        .s_j     (s_j),
        .s_t     (s_t)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= KEYLOAD;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        init_wr   = 1'b0;
        swap_wr   = 1'b0;
        busy      = 1'b0;
        unique case (state)
            KEYLOAD: if (key_acc && last_beat) state_nxt = INIT;
            INIT: begin
                init_wr = 1'b1;
                busy    = 1'b1;
                if (i_q == 8'hFF) state_nxt = KSA_J;
            end
            KSA_J: begin
                busy      = 1'b1;
                state_nxt = KSA_SW;
            end
            KSA_SW: begin
                swap_wr   = 1'b1;
                busy      = 1'b1;
                state_nxt = (i_q == 8'hFF) ? PRGA_J : KSA_J;
            end
            PRGA_J: begin
                busy      = !emitted_q;
                state_nxt = PRGA_SW;
            end
            PRGA_SW: begin
                swap_wr   = 1'b1;
                busy      = !emitted_q;
                state_nxt = drop ? PRGA_J : HOLD;
            end
            HOLD: if (ks_ready) state_nxt = PRGA_J;
            default: state_nxt = KEYLOAD;
        endcase
        if (rekey) begin
            state_nxt = KEYLOAD;
            init_wr   = 1'b0;
            swap_wr   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (key_acc) key_mem[len_q] <= key_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_q       <= '0;
            j_q       <= '0;
            len_q     <= '0;
            klen_m1_q <= '0;
            kidx_q    <= '0;
            emitted_q <= 1'b0;
            ks_valid  <= 1'b0;
            ks_data   <= '0;
        end else if (rekey) begin
            len_q     <= '0;
            emitted_q <= 1'b0;
            ks_valid  <= 1'b0;
        end else begin
            unique case (state)
                KEYLOAD: if (key_acc) begin
                    if (last_beat) begin
                        klen_m1_q <= len_q;
                        len_q     <= '0;
                        i_q       <= '0;
                        j_q       <= '0;
                        kidx_q    <= '0;
                        emitted_q <= 1'b0;
                    end else begin
                        len_q <= len_q + 1'b1;
                    end
                end
                INIT:   i_q <= i_q + 8'd1;   // wraps to 0 for KSA
                KSA_J:  j_q <= j_q + s_i + key_mem[kidx_q];
                KSA_SW: begin
                    kidx_q <= (kidx_q == klen_m1_q) ? '0 : kidx_q + 1'b1;
                    if (i_q == 8'hFF) begin
                        i_q <= 8'd1;
                        j_q <= '0;
                    end else begin
                        i_q <= i_q + 8'd1;
                    end
                end
                PRGA_J: j_q <= j_q + s_i;
                PRGA_SW: begin
                    i_q <= i_q + 8'd1;
                    if (!drop) begin
                        ks_valid  <= 1'b1;
                        ks_data   <= out_byte;
                        emitted_q <= 1'b1;
                    end
                end
                HOLD: if (ks_ready) ks_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_keystream.sv
module tb_rc4_keystream;

    typedef logic [7:0] b8;

    logic        clk = 1'b0;
    logic        rst, rekey, key_valid, key_last, ks_ready;
    logic [7:0]  key_data;
    logic [11:0] discard;
    logic        key_ready, ks_valid, busy;
    logic [7:0]  ks_data;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    rc4_keystream #(.MAX_KEY_BYTES(32), .DISCARD_W(12)) dut (
        .clk       (clk),
        .rst       (rst),
        .rekey     (rekey),
        .key_valid (key_valid),
        .key_data  (key_data),
        .key_last  (key_last),
        .key_ready (key_ready),
        .discard   (discard),
        .ks_valid  (ks_valid),
        .ks_data   (ks_data),
        .ks_ready  (ks_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int eff_drop(input int d);
`ifdef RC4_DISCARD_EN
        return d;
`else
        return 0;
`endif
    endfunction

    // Plain textbook RC4 with drop-N, written with modulo arithmetic on int arrays.
    task automatic rc4_model(input b8 key[$], input int drop, input int n, output b8 ks[$]);
        int s[256];
        int i, j, t, d;
        b8  q[$];
        d = drop;
        for (int k = 0; k < 256; k++) s[k] = k;
        j = 0;
        for (int k = 0; k < 256; k++) begin
            j = (j + s[k] + int'(key[k % key.size()])) % 256;
            t = s[k]; s[k] = s[j]; s[j] = t;
        end
        i = 0; j = 0;
        while (q.size() < n) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            if (d > 0) d--;
            else q.push_back(b8'(s[(s[i] + s[j]) % 256]));
        end
        ks = q;
    endtask

    task automatic load_key(input b8 kq[$], input int disc);
        for (int k = 0; k < kq.size(); k++) begin
            @(negedge clk);
            key_valid = 1'b1;
            key_data  = kq[k];
            key_last  = (k == kq.size() - 1);
            discard   = 12'(disc);
        end
        @(negedge clk);
        key_valid = 1'b0;
        key_last  = 1'b0;
    endtask

    // Called at the negedge right after the last key beat was accepted.
    task automatic run_stream(input int n, input bit rnd, input int budget,
                              output b8 got[$], output int lat, output int gap_bad);
        b8  q[$];
        b8  held = '0;
        bit seen = 1'b0;
        bit stalled = 1'b0;
        int t0 = cyc;
        int last_acc = -1;
        lat = -1;
        gap_bad = 0;
        for (int c = 0; c < budget && q.size() < n; c++) begin
            if (stalled) begin
                chk("stall_vld", 32'(ks_valid), 1);
                chk("stall_dat", 32'(ks_data), 32'(held));
            end
            if (ks_valid && !seen) begin
                seen = 1'b1;
                lat  = cyc - t0;
                chk("busy_at_first_vld", 32'(busy), 0);
            end
            ks_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled  = ks_valid && !ks_ready;
            held     = ks_data;
            if (ks_valid && ks_ready) begin
                q.push_back(ks_data);
                if (last_acc >= 0 && cyc - last_acc != 3) gap_bad++;
                last_acc = cyc;
            end
            @(negedge clk);
        end
        ks_ready = 1'b0;
        chk("stream_count", 32'(q.size()), 32'(n));
        got = q;
    endtask

    task automatic do_rekey();
        @(negedge clk);
        rekey = 1'b1;
        @(negedge clk);
        rekey = 1'b0;
    endtask

    initial begin
        b8  kq[$];
        b8  got[$];
        b8  exp_q[$];
        b8  exp_key[10];
        b8  exp_wiki[6];
        int lat, gb, acc, d, w;

        exp_key  = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
        exp_wiki = '{8'h60, 8'h44, 8'hDB, 8'h6D, 8'h41, 8'hB7};

        rst = 1'b1; rekey = 1'b0; key_valid = 1'b0; key_last = 1'b0;
        key_data = '0; discard = '0; ks_ready = 1'b0;
        #2 rst = 1'b0;
        #10;
        chk("rst_key_ready", 32'(key_ready), 1);
        chk("rst_ks_valid", 32'(ks_valid), 0);
        chk("rst_ks_data", 32'(ks_data), 0);
        chk("rst_busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b1;

        // "Key", no drop: known vector, latency and steady-state rate.
        kq = '{8'h4B, 8'h65, 8'h79};
        load_key(kq, 0);
        chk("busy_after_key", 32'(busy), 1);
        chk("key_ready_after_key", 32'(key_ready), 0);
        run_stream(10, 1'b0, 3000, got, lat, gb);
        chk("key_latency", 32'(lat), 770);
        chk("key_rate_gaps", 32'(gb), 0);
        for (int k = 0; k < 10; k++) chk($sformatf("key_byte%0d", k), 32'(got[k]), 32'(exp_key[k]));

        // "Wiki" with random back-pressure.
        do_rekey();
        kq = '{8'h57, 8'h69, 8'h6B, 8'h69};
        load_key(kq, 0);
        run_stream(6, 1'b1, 3000, got, lat, gb);
        chk("wiki_latency", 32'(lat), 770);
        for (int k = 0; k < 6; k++) chk($sformatf("wiki_byte%0d", k), 32'(got[k]), 32'(exp_wiki[k]));

        // "Secret" with discard 3.
        do_rekey();
        kq = '{8'h53, 8'h65, 8'h63, 8'h72, 8'h65, 8'h74};
`ifdef RC4_DISCARD_EN
        exp_q = '{8'h05, 8'h3C, 8'hA8, 8'h7B, 8'h59};
`else
        exp_q = '{8'h04, 8'hD4, 8'h6B, 8'h05};
`endif
        load_key(kq, 3);
        run_stream(exp_q.size(), 1'b0, 3000, got, lat, gb);
        chk("secret_latency", 32'(lat), 32'(770 + 2 * eff_drop(3)));
        for (int k = 0; k < exp_q.size(); k++)
            chk($sformatf("secret_byte%0d", k), 32'(got[k]), 32'(exp_q[k]));

        // Random keys and drop counts against the model.
        for (int r = 0; r < 3; r++) begin
            do_rekey();
            kq = {};
            for (int k = 0; k < int'($urandom_range(1, 32)); k++) kq.push_back(b8'($urandom_range(0, 255)));
            d = int'($urandom_range(0, 4));
            rc4_model(kq, eff_drop(d), 8, exp_q);
            load_key(kq, d);
            run_stream(8, 1'b1, 4000, got, lat, gb);
            chk($sformatf("rand%0d_latency", r), 32'(lat), 32'(770 + 2 * eff_drop(d)));
            for (int k = 0; k < 8; k++)
                chk($sformatf("rand%0d_byte%0d", r, k), 32'(got[k]), 32'(exp_q[k]));
        end

        // Overlong key without key_last: only the first 32 bytes count.
        do_rekey();
        kq = {};
        for (int k = 0; k < 34; k++) kq.push_back(b8'($urandom_range(0, 255)));
        acc = 0;
        for (int k = 0; k < 34; k++) begin
            @(negedge clk);
            if (key_ready) acc++;
            key_valid = 1'b1;
            key_last  = 1'b0;
            key_data  = kq[k];
            discard   = '0;
        end
        @(negedge clk);
        key_valid = 1'b0;
        chk("overlong_accepted", 32'(acc), 32);
        chk("overlong_key_ready", 32'(key_ready), 0);
        kq = kq[0:31];
        rc4_model(kq, 0, 4, exp_q);
        run_stream(4, 1'b0, 3000, got, lat, gb);
        for (int k = 0; k < 4; k++) chk($sformatf("overlong_byte%0d", k), 32'(got[k]), 32'(exp_q[k]));

        // Rekey in the middle of KSA, then reload "Key".
        do_rekey();
        kq = '{8'h4B, 8'h65, 8'h79};
        load_key(kq, 0);
        repeat (400) @(negedge clk);
        chk("midksa_busy", 32'(busy), 1);
        chk("midksa_vld", 32'(ks_valid), 0);
        rekey = 1'b1;
        @(negedge clk);
        rekey = 1'b0;
        chk("rekey_key_ready", 32'(key_ready), 1);
        chk("rekey_busy", 32'(busy), 0);
        chk("rekey_vld", 32'(ks_valid), 0);
        load_key(kq, 0);
        run_stream(5, 1'b0, 3000, got, lat, gb);
        chk("rekey_latency", 32'(lat), 770);
        for (int k = 0; k < 5; k++) chk($sformatf("rekey_byte%0d", k), 32'(got[k]), 32'(exp_key[k]));

        // Asynchronous reset while a byte is held.
        do_rekey();
        load_key(kq, 0);
        w = 0;
        while (!ks_valid && w < 2000) begin
            @(negedge clk);
            w++;
        end
        chk("hold_vld", 32'(ks_valid), 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_vld", 32'(ks_valid), 0);
        chk("arst_key_ready", 32'(key_ready), 1);
        chk("arst_busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b1;
        load_key(kq, 0);
        run_stream(3, 1'b1, 3000, got, lat, gb);
        for (int k = 0; k < 3; k++) chk($sformatf("arst_byte%0d", k), 32'(got[k]), 32'(exp_key[k]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
